// File: rtl/ramdma_pkg.sv
// Shared definitions for the ramdma block copy/fill engine: FSM encoding,
// transfer unit sizes and mode encodings.
package ramdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int UNIT_WORD_SZ = 4;
  localparam int UNIT_BYTE_SZ = 1;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ramdma_lane.sv
// Byte-lane helper: in byte mode picks lane i_sel of i_word and replicates it
// on all four lanes; in word mode passes i_word through unchanged.
module ramdma_lane (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_sel,
  input  logic        i_byte_mode,
  output logic [31:0] o_word
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_sel)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign o_word = i_byte_mode ? {4{w_byte}} : i_word;

endmodule

// File: rtl/ramdma.sv
// RAM block copy/fill engine behind an external arbiter.
// Optional checksum accumulator enabled by defining RAMDMA_CHECKSUM_EN.
module ramdma
  import ramdma_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_fill,
  input  logic              unit_byte,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       fill_val,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  input  logic              gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [31:0]       r_data;
  logic              r_mode, r_unit;
  logic [ADDR_W-1:0] w_step;
  logic [31:0]       w_rd_word, w_wr_word;

  assign w_step = r_unit ? ADDR_W'(UNIT_BYTE_SZ) : ADDR_W'(UNIT_WORD_SZ);

  ramdma_lane u_rd_lane (
    .i_word      (ram_rdata),
    .i_sel       (r_src[1:0]),
    .i_byte_mode (r_unit),
    .o_word      (w_rd_word)
  );

  // r_data already holds the byte in lane 0 (fill) or on every lane (copy).
  ramdma_lane u_wr_lane (
    .i_word      (r_data),
    .i_sel       (2'b00),
    .i_byte_mode (r_unit),
    .o_word      (w_wr_word)
  );

  assign ram_wdata = w_wr_word;
  assign ram_be    = r_unit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    done     = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len == '0)                  w_next = ST_DONE;
          else if (mode_fill == MODE_FILL) w_next = ST_WR;
          else                            w_next = ST_RD;
        end
      end
      ST_RD: begin
        ram_en   = gnt;
        ram_addr = r_src;
        if (gnt) w_next = ST_WR;
      end
      ST_WR: begin
        ram_en   = gnt;
        ram_we   = gnt;
        ram_addr = r_dst;
        if (gnt) begin
          if (r_rem == LEN_W'(1))     w_next = ST_DONE;
          else if (r_mode == MODE_FILL) w_next = ST_WR;
          else                        w_next = ST_RD;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_data <= '0;
      r_mode <= 1'b0;
      r_unit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          // Word transfers are always word aligned.
          r_src  <= unit_byte ? src : {src[ADDR_W-1:2], 2'b00};
          r_dst  <= unit_byte ? dst : {dst[ADDR_W-1:2], 2'b00};
          r_rem  <= len;
          r_data <= fill_val;
          r_mode <= mode_fill;
          r_unit <= unit_byte;
        end
        ST_RD: if (gnt) begin
          r_data <= w_rd_word;
          r_src  <= r_src + w_step;
        end
        ST_WR: if (gnt) begin
          r_dst <= r_dst + w_step;
          r_rem <= r_rem - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef RAMDMA_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_csum <= '0;
    end else if (r_state == ST_WR && gnt) begin
      r_csum <= r_csum + (r_unit ? {24'h0, w_wr_word[7:0]} : w_wr_word);
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = 32'h0;
`endif

endmodule
